// File: rtl/div_share_ctrl.sv
// Round-robin front end that shares one iterative divider core between two FPU lanes.
// Handles operand capture, core start/complete, divide-by-zero bypass and a WAIT timeout.
module div_share_ctrl #(
  parameter int W       = 24,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         core_start,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic         core_done,
  input  logic [W-1:0] core_q,
  input  logic [W-1:0] core_r,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_dz,
  output logic         rsp_to
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          dz_q, dz_d;
  logic          to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;

  logic          grant0, grant1, accept, sel_id;
  logic [W-1:0]  sel_a, sel_b;

  // Grant only in IDLE; on contention the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign accept = grant0 | grant1;
  assign sel_id = grant1;
  assign sel_a  = grant1 ? req1_a : req0_a;
  assign sel_b  = grant1 ? req1_b : req0_b;

  // State register plus all datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (sel_b == '0) ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done || cnt_q == CNT_MAX) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A done on the final count cycle wins over the timeout.
  always_comb begin
    last_d = last_q;
    id_d   = id_q;
    dz_d   = dz_q;
    to_d   = to_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_d = sel_id;
          id_d   = sel_id;
          a_d    = sel_a;
          b_d    = sel_b;
          if (sel_b == '0) begin
            quo_d = '1;
            rem_d = sel_a;
            dz_d  = 1'b1;
            to_d  = 1'b0;
          end
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (core_done) begin
          quo_d = core_q;
          rem_d = core_r;
          dz_d  = 1'b0;
          to_d  = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          quo_d = '0;
          rem_d = '0;
          dz_d  = 1'b0;
          to_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          dz_d = 1'b0;
          to_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    core_start = (state_q == ISSUE);
    core_a     = a_q;
    core_b     = b_q;
    rsp_valid  = (state_q == RESP);
    rsp_id     = id_q;
    rsp_q      = quo_q;
    rsp_r      = rem_q;
    rsp_dz     = dz_q;
    rsp_to     = to_q;
  end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Two-requester controller that shares one iterative 24-bit mantissa divider core between FPU lanes. It arbitrates round-robin, latches operands, and pulses the core start. It also waits for completion with a timeout guard, short-circuits divide-by-zero without using the core, and returns the result tagged with the requester id over a valid/ready response port. It sits between the FPU divide issue logic and the shared divider datapath.

## Interface
- W, 24: operand/quotient/remainder width.
- TIMEOUT, 64: max cycles spent in WAIT before forced abort; must be ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operand pair.
- req0_ready / req1_ready  out  1  operand pair accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  W  dividend, divisor.
- core_start  out  1  one-cycle start pulse to divider core.
- core_a, core_b  out  W  registered operands; held stable from ISSUE until leaving WAIT.
- core_done  in  1  core result valid (single-cycle pulse).
- core_q, core_r  in  W  core quotient, remainder.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response (0/1).
- rsp_q, rsp_r  out  W  quotient, remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_to  out  1  core timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- Round-robin pointer `last`, reset value 1, so req0 wins the first contention.
- Grant (combinational, IDLE only): if only one valid, grant it; if both valid, grant the requester ≠ `last`.
- reqN_ready = (state==IDLE) && grant==N. Ready depends on valid; at most one ready per cycle.
- On accept: latch a, b, id into registers; set `last`=id.
  - If b==0: go to RESP with rsp_q = all ones, rsp_r = a, rsp_dz=1, rsp_to=0. Core not started.
  - Otherwise go to ISSUE.
- ISSUE: core_start=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT: if core_done, latch core_q/core_r into rsp_q/rsp_r (dz=0, to=0) and go to RESP. Otherwise increment the counter. When counter == TIMEOUT-1 without done, go to RESP with q=0, r=0, rsp_to=1.
- RESP: rsp_valid=1; rsp_* stable until rsp_ready sampled high. After that, go to IDLE and clear flags.
- core_done outside WAIT is ignored. core_done on the same cycle the counter hits TIMEOUT-1 counts as done, not timeout.
- A requester deasserting valid before being granted is legal; nothing is latched.
- Reset (any state, any time): state IDLE, `last`=1, counter 0, all outputs 0, including core_a/core_b and rsp_* fields. An in-flight core operation is abandoned. A later stray core_done is ignored because the FSM is in IDLE.

## Timing
- Accept cycle = T0 (IDLE, ready high).
- Normal path: ISSUE with core_start at T0+1; WAIT from T0+2. A core_done at cycle Td gives rsp_valid at Td+1.
- Divide-by-zero path: rsp_valid at T0+1.
- Timeout path: rsp_valid exactly TIMEOUT+2 cycles after T0.
- rsp_ready high in the first RESP cycle: IDLE on the next cycle. The next accept is possible in that IDLE cycle, so back-to-back period = service time + 1.
- No operand is accepted while busy; the requester must hold valid and its operands until ready.

## Test plan
- Single request: req0 a=0xD6978D, b=0x9B5C29; core model returns done 3 cycles after start with q=0x000001, r=0x3B3B64. Required: core_start one cycle at T0+1; rsp_valid at T0+5 with id=0, q=0x000001, r=0x3B3B64, dz=0, to=0.
- Contention: both valid from reset with req0 a=0x000010,b=0x000003 and req1 a=0x000064,b=0x00000A. Required: req0 granted first (q=5, r=1); req1 granted in the next IDLE (q=10, r=0). With both held, grants alternate 0,1,0,1.
- Divide-by-zero: req1 a=0x123456, b=0. Required: core_start never asserts; rsp_valid at T0+1 with id=1, q=0xFFFFFF, r=0x123456, dz=1.
- Timeout: core never asserts done, TIMEOUT=64. Required: rsp_valid 66 cycles after accept with to=1, q=0, r=0. A core_done injected after the timeout is ignored.
- Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_* stable; both ready outputs stay 0; IDLE is entered only after the handshake.
- Reset mid-operation: assert rstn low during WAIT. Required: all outputs 0 immediately (async). After release, req0 wins the first contention, and a late core_done produces no response.
